serial_link_scheduler: RTL and testbench
========================================

SERIAL_LINK_SCHEDULER -- requirements
Module: serial_link_scheduler

Interface
REQ-001 Parameter WIDTH, default 8: frame length in bits (legal range 2..32).
REQ-002 Parameter GAP, default 1: idle cycles inserted after each frame (legal range 0..15).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 has a frame pending.
REQ-006 req0_data  input  WIDTH  requester 0 parallel frame data.
REQ-007 req0_ready  output  1  requester 0 frame accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 has a frame pending.
REQ-009 req1_data  input  WIDTH  requester 1 parallel frame data.
REQ-010 req1_ready  output  1  requester 1 frame accepted this cycle.
REQ-011 serial_out  output  1  registered serial bit stream, LSB first (right shift).
REQ-012 frame_active  output  1  registered; high while serial_out carries a valid frame bit.
REQ-013 grant_id  output  1  registered; requester owning the current or most recent frame.
REQ-014 done  output  1  registered one-cycle pulse marking the final bit of a frame.

Function
REQ-015 FSM states IDLE, SHIFT, GAP; only transitions: IDLE->SHIFT on accept, SHIFT->GAP on last bit (GAP>0), SHIFT->IDLE on last bit (GAP=0), GAP->IDLE after GAP cycles.
REQ-016 Accept = reqN_valid & reqN_ready at a rising edge; reqN_ready is combinational, high only in IDLE and only for the selected requester; never both readies high.
REQ-017 Selection in IDLE: single valid requester is selected; both valid -> requester other than last_grant; last_grant resets to 1 (req0 wins first tie).
REQ-018 On accept at edge T0: capture selected data, grant_id and last_grant <= selected id, state <= SHIFT, bit counter <= WIDTH-1.
REQ-019 Bit k (k=0..WIDTH-1) of accepted data is on serial_out in cycle T0+1+k; frame_active high for exactly those WIDTH cycles.
REQ-020 done high only in the cycle carrying bit WIDTH-1.
REQ-021 GAP state: serial_out=0, frame_active=0, all ready low, for exactly GAP cycles; then IDLE.
REQ-022 Minimum accept-to-accept spacing = WIDTH+GAP+1 cycles (one IDLE cycle always precedes an accept).
REQ-023 Requester must hold valid and data stable until ready; valid withdrawn before accept is legal and produces no frame.
REQ-024 Valid asserted during SHIFT or GAP is ignored until IDLE; no data captured mid-frame.
REQ-025 Outside frames serial_out=0 and done=0; grant_id holds its last value.
REQ-026 Captured frame is immune to later changes of reqN_data.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, serial_out=0, frame_active=0, done=0, grant_id=0, last_grant=1, counter=0, shift storage=0.
REQ-028 Reset mid-frame abandons the frame: no further bits, no done; after release, pending valid is accepted from IDLE as a fresh frame.
REQ-029 Readies are low while rst_n is low.

Verification (WIDTH=8, GAP=1 unless stated)
REQ-030 Reset, req0 sends 8'hA5 -> req0_ready high one cycle; serial_out 1,0,1,0,0,1,0,1 over 8 cycles with frame_active high; done on 8th bit; grant_id=0.
REQ-031 req0 8'h0F and req1 8'hF0 both valid at once, held -> req0 frame first, 1 GAP cycle, 1 IDLE cycle, then req1 frame; accepts 10 cycles apart.
REQ-032 req1 alone valid for 3 consecutive frames 8'h01,8'h80,8'hFF -> all granted to req1, grant_id=1, each done pulse present.
REQ-033 rst_n low for 1 cycle after 3 bits of 8'hC3 -> serial_out/frame_active drop immediately, no done; after release, held req0 frame 8'hC3 re-sent in full.
REQ-034 req1_valid raised mid-frame of req0 -> req1_ready stays low until next IDLE, then req1 accepted.
REQ-035 WIDTH=4, GAP=0, both valid continuously -> alternating grants 0,1,0,1; accepts 5 cycles apart; frame_active low exactly 1 cycle between frames.

Source files
------------

// File: rtl/serial_link_scheduler.sv
// Two-requester serializer: arbitrates frames, shifts them out LSB first, then idles GAP cycles.
// Latency: first bit on serial_out the cycle after accept; WIDTH+GAP+1 cycles accept-to-accept.
// Backpressure: ready is high only in IDLE for the selected requester; others wait holding valid/data.
module serial_link_scheduler #(
   parameter int WIDTH = 8,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             serial_out,
   output logic             frame_active,
   output logic             grant_id,
   output logic             done
);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

   state_t           state;
   logic [4:0]       cnt;
   logic [WIDTH-1:0] shreg;
   logic             last_grant;
   logic             sel_id;
   logic [WIDTH-1:0] sel_dat;
   logic             accept;

   // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
   always_comb begin
      sel_id     = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
      sel_dat    = sel_id ? req1_data : req0_data;
      req0_ready = rst_n & (state == ST_IDLE) & req0_valid & ~sel_id;
      req1_ready = rst_n & (state == ST_IDLE) & req1_valid & sel_id;
      accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
   end

   // Frame sequencer: bit 0 goes out directly on accept, the rest come from the shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         shreg        <= '0;
         last_grant   <= 1'b1;
         grant_id     <= 1'b0;
         serial_out   <= 1'b0;
         frame_active <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               serial_out   <= 1'b0;
               frame_active <= 1'b0;
               done         <= 1'b0;
               if (accept) begin
                  shreg        <= sel_dat >> 1;
                  serial_out   <= sel_dat[0];
                  frame_active <= 1'b1;
                  grant_id     <= sel_id;
                  last_grant   <= sel_id;
                  cnt          <= 5'(WIDTH - 1);
                  state        <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // cnt holds the number of bits still to follow the one currently on the wire
               if (cnt != 5'd0) begin
                  serial_out <= shreg[0];
                  shreg      <= shreg >> 1;
                  cnt        <= cnt - 5'd1;
                  done       <= (cnt == 5'd1);
               end else begin
                  serial_out   <= 1'b0;
                  frame_active <= 1'b0;
                  done         <= 1'b0;
                  if (GAP > 0) begin
                     cnt   <= 5'(GAP - 1);
                     state <= ST_GAP;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               if (cnt == 5'd0) state <= ST_IDLE;
               else             cnt   <= cnt - 5'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_link_scheduler.sv
// Bench for serial_link_scheduler: table of single-frame arbitration cases plus multi-cycle sequences.
// Expected grants are queued by the stimulus; the monitor expands each accept into per-bit expectations.
// A second instance (WIDTH=4, GAP=0) checks back-to-back alternation under continuous valid.
module tb_serial_link_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       v0, v1;
   logic [7:0] d0, d1;
   logic       r0, r1, so, fa, gid, dn;

   logic       b_rst_n;
   logic       b_v0, b_v1;
   logic [3:0] b_d0, b_d1;
   logic       b_r0, b_r1, b_so, b_fa, b_gid, b_dn;

   serial_link_scheduler #(.WIDTH(8), .GAP(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
      .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
      .serial_out(so), .frame_active(fa), .grant_id(gid), .done(dn));

   serial_link_scheduler #(.WIDTH(4), .GAP(0)) dut_b (
      .clk(clk), .rst_n(b_rst_n),
      .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
      .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
      .serial_out(b_so), .frame_active(b_fa), .grant_id(b_gid), .done(b_dn));

   always #5 clk = ~clk;

   typedef struct packed {logic b; logic d; logic g;} bit_t;
   typedef struct {logic v0; logic [7:0] d0; logic v1; logic [7:0] d1; int exp_id;} vec_t;

   bit_t exp_bits[$];
   int   exp_gnt[$];
   bit_t b_bits[$];
   int   b_exp[$];
   vec_t vt[9];

   int   n_chk = 0, n_fail = 0;
   int   cyc = 0;
   int   acc_cnt = 0, last_acc = 0, last_spacing = 0;
   logic mon_gid = 1'b0;
   int   b_acc = 0, b_last = 0;
   logic b_win = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic wait_acc(input int prev, input string nm);
      int n = 0;
      while (acc_cnt == prev && n < 40) begin
         @(posedge clk);
         n++;
      end
      chk(nm, acc_cnt > prev, 1);
   endtask

   // cycle counter used for accept spacing
   always @(posedge clk) cyc++;

   // main instance monitor: per-cycle frame/idle checks, then accept handling
   always @(negedge clk) begin
      bit_t       e;
      int         a_id, e_id;
      logic [7:0] a_dat;
      if (!rst_n) begin
         exp_bits.delete();
         mon_gid = 1'b0;
         chk("rst_frame_active", fa, 0);
         chk("rst_serial_out", so, 0);
         chk("rst_done", dn, 0);
         chk("rst_grant_id", gid, 0);
         chk("rst_ready", {r0, r1}, 0);
      end else begin
         chk("one_ready", r0 & r1, 0);
         if (exp_bits.size() != 0) begin
            chk("ready_mid_frame", {r0, r1}, 0);
            e = exp_bits.pop_front();
            chk("frame_active", fa, 1);
            chk("serial_out", so, e.b);
            chk("done", dn, e.d);
            chk("grant_id", gid, e.g);
         end else begin
            chk("idle_frame_active", fa, 0);
            chk("idle_serial_out", so, 0);
            chk("idle_done", dn, 0);
            chk("idle_grant_id", gid, mon_gid);
         end
         if ((r0 & v0) | (r1 & v1)) begin
            a_id = (r1 & v1) ? 1 : 0;
            chk("accept_expected", exp_gnt.size() != 0, 1);
            if (exp_gnt.size() != 0) begin
               e_id = exp_gnt.pop_front();
               chk("accept_id", a_id, e_id);
               a_dat = (e_id != 0) ? d1 : d0;
               for (int k = 0; k < 8; k++)
                  exp_bits.push_back('{a_dat[k], (k == 7), e_id[0]});
               mon_gid = e_id[0];
               acc_cnt++;
               last_spacing = cyc - last_acc;
               last_acc = cyc;
            end
         end
      end
   end

   // second instance monitor, active only inside its test window
   always @(negedge clk) begin
      bit_t       e;
      int         e_id;
      logic [3:0] a_dat;
      if (b_win) begin
         chk("b_one_ready", b_r0 & b_r1, 0);
         if (b_bits.size() != 0) begin
            e = b_bits.pop_front();
            chk("b_frame_active", b_fa, 1);
            chk("b_serial_out", b_so, e.b);
            chk("b_done", b_dn, e.d);
            chk("b_grant_id", b_gid, e.g);
         end else begin
            chk("b_idle_frame_active", b_fa, 0);
            chk("b_idle_serial_out", b_so, 0);
         end
         if (b_r0 | b_r1) begin
            if (b_exp.size() == 0) begin
               b_win = 1'b0;
            end else begin
               e_id = b_exp.pop_front();
               chk("b_accept_id", b_r1, e_id);
               if (b_acc > 0) chk("b_spacing", cyc - b_last, 5);
               b_last = cyc;
               b_acc++;
               a_dat = (e_id != 0) ? b_d1 : b_d0;
               for (int k = 0; k < 4; k++)
                  b_bits.push_back('{a_dat[k], (k == 3), e_id[0]});
            end
         end
      end
   end

   initial begin
      int prev;
      vt[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 0};
      vt[1] = '{1'b0, 8'h00, 1'b1, 8'h01, 1};
      vt[2] = '{1'b0, 8'h00, 1'b1, 8'h80, 1};
      vt[3] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1};
      vt[4] = '{1'b1, 8'h0F, 1'b1, 8'hF0, 0};
      vt[5] = '{1'b1, 8'h55, 1'b1, 8'hAA, 1};
      vt[6] = '{1'b1, 8'h12, 1'b1, 8'h34, 0};
      vt[7] = '{1'b1, 8'h00, 1'b0, 8'h00, 0};
      vt[8] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1};

      // reset with both valids high: readies must stay low
      rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
      b_rst_n = 1'b0; b_v0 = 1'b1; b_v1 = 1'b1; b_d0 = 4'h9; b_d1 = 4'h6;
      repeat (3) @(posedge clk);
      #1 v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // table-driven single frames
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         prev = acc_cnt;
         exp_gnt.push_back(vt[i].exp_id);
         v0 = vt[i].v0; d0 = vt[i].d0; v1 = vt[i].v1; d1 = vt[i].d1;
         wait_acc(prev, "table_accept_timeout");
         #1 v0 = 1'b0; v1 = 1'b0;
         repeat (12) @(posedge clk);
      end

      // tie from fresh reset: req0 first, req1 ten cycles later
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      exp_gnt.push_back(0); exp_gnt.push_back(1);
      prev = acc_cnt;
      v0 = 1'b1; d0 = 8'h0F; v1 = 1'b1; d1 = 8'hF0;
      wait_acc(prev, "tie_first_timeout");
      #1 v0 = 1'b0;
      prev = acc_cnt;
      wait_acc(prev, "tie_second_timeout");
      #1 v1 = 1'b0;
      chk("tie_spacing", last_spacing, 10);
      repeat (12) @(posedge clk);

      // req1 raised mid-frame waits for the next IDLE
      #1;
      exp_gnt.push_back(0);
      prev = acc_cnt;
      v0 = 1'b1; d0 = 8'h3C;
      wait_acc(prev, "mid_first_timeout");
      #1 v0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_gnt.push_back(1);
      prev = acc_cnt;
      v1 = 1'b1; d1 = 8'h96;
      wait_acc(prev, "mid_second_timeout");
      #1 v1 = 1'b0;
      chk("mid_spacing", last_spacing, 10);
      repeat (12) @(posedge clk);

      // reset after three bits abandons the frame; held request is re-sent in full
      #1;
      exp_gnt.push_back(0);
      prev = acc_cnt;
      v0 = 1'b1; d0 = 8'hC3;
      wait_acc(prev, "abort_first_timeout");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_frame_active", fa, 0);
      chk("abort_serial_out", so, 0);
      chk("abort_done", dn, 0);
      exp_gnt.push_back(0);
      prev = acc_cnt;
      @(posedge clk); #1 rst_n = 1'b1;
      wait_acc(prev, "abort_resend_timeout");
      #1 v0 = 1'b0;
      repeat (12) @(posedge clk);

      // WIDTH=4, GAP=0 instance: continuous tie alternates 0,1,0,1 five cycles apart
      #1;
      b_exp.push_back(0); b_exp.push_back(1); b_exp.push_back(0); b_exp.push_back(1);
      b_win = 1'b1;
      b_rst_n = 1'b1;
      for (int n = 0; n < 60 && b_win; n++) @(posedge clk);
      chk("b_window_closed", b_win, 0);
      chk("b_accept_count", b_acc, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
